// File: rtl/uart_tx.sv
// uart_tx: accepts a byte over valid/ready and sends it as an idle-high async serial frame:
// one start bit (0), DATA_BITS data bits LSB first, one stop bit (1).
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 10,
    parameter int unsigned DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_done,
    output logic                 serial_out
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IdxW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);
    localparam logic [IdxW-1:0] IdxMax = IdxW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [IdxW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   serial_q, serial_d;
    logic                   done_q, done_d;

    logic bit_end;
    assign bit_end = (cnt_q == CntMax);

    // State, counters, shift register and registered outputs; reset aborts any frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            serial_q <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            serial_q <= serial_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic; the line value is derived from the next state so the flop
    // presents each bit in the first cycle of its slot.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        done_d   = 1'b0;
        serial_d = 1'b1;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                idx_d = '0;
                if (tx_valid) begin
                    state_d = StStart;
                    shift_d = tx_data;
                end
            end
            StStart: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = StData;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StData: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    if (idx_q == IdxMax) begin
                        state_d = StStop;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StStop: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        case (state_d)
            StStart: serial_d = 1'b0;
            StData:  serial_d = shift_d[0];
            default: serial_d = 1'b1;
        endcase
    end

    assign tx_ready   = (state_q == StIdle);
    assign tx_done    = done_q;
    assign serial_out = serial_q;

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter for the UART link: accepts a byte over a valid/ready handshake and drives an idle-high asynchronous serial line. Each frame is one start bit (0), DATA_BITS data bits sent LSB first, and one stop bit (1). The line idles high and returns high on reset, which matches the reset-high synchronizer at the receiving end. The block sits on the transmit side of the design, opposite the receive block.

## Interface
- CLKS_PER_BIT, 10: clock cycles per serial bit; must be ≥ 1.
- DATA_BITS, 8: data bits per frame; must be ≥ 1.

- clk  input  1  system clock; all logic on the rising edge
- rst  input  1  synchronous, active-high reset
- tx_data  input  DATA_BITS  byte to send; sampled only on accept
- tx_valid  input  1  request to send tx_data
- tx_ready  output  1  high when idle and able to accept
- tx_done  output  1  one-cycle pulse when a frame finishes
- serial_out  output  1  serial line, idle high

## Operation
- The clock is single-domain. Reset is synchronous and active-high: with rst high at a rising edge, the state goes to IDLE, serial_out=1, tx_done=0, and the counters clear. tx_ready=1 from the first cycle after reset.
- **Accept.** A transfer is accepted on a rising edge where tx_valid && tx_ready. tx_data is captured into an internal shift register on that edge. Later changes to tx_data have no effect on the frame in flight.
- **tx_ready** is high only in IDLE. tx_valid while busy is ignored and creates no queue.
- **States:**
  - IDLE: serial_out=1. On accept, go to START.
  - START: serial_out=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: serial_out = shift_reg[0] for CLKS_PER_BIT cycles per bit. Shift right at each bit boundary. After bit DATA_BITS-1, go to STOP.
  - STOP: serial_out=1 for CLKS_PER_BIT cycles, then go to IDLE and pulse tx_done.
- **Bit timer.**
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
  - Width is ceil(log2(CLKS_PER_BIT)), minimum 1 bit.
  - Bit index width is ceil(log2(DATA_BITS)), minimum 1 bit.
- **serial_out** comes directly from a flop, with no combinational path from inputs, so it is glitch-free.
- **Reset mid-frame** aborts the frame: serial_out=1 from the next cycle, no tx_done, captured data discarded.
- **rst together with tx_valid:** reset wins and nothing is accepted.

## Timing
- Let accept happen at rising edge N, and let C = CLKS_PER_BIT and F = (DATA_BITS+2)·C.
- Start bit: cycles N+1 .. N+C.
- Data bit k: cycles N+1+(k+1)·C .. N+(k+2)·C.
- Stop bit: cycles N+1+(DATA_BITS+1)·C .. N+F.
- At cycle N+F+1, tx_done=1 for exactly one cycle and tx_ready=1 in the same cycle.
- tx_ready=0 for cycles N+1 .. N+F.
- **Back-to-back:** if tx_valid is held high, the next accept is at edge N+F+1. The next start bit begins at N+F+2, so there is exactly one extra idle-high cycle between frames. The frame period is F+1 cycles.
- **Latency:** accept to first start-bit cycle is 1 clock.

## Test plan
1. **Reset:** hold rst 3 cycles with tx_valid=1 and tx_data=0x3C.
   - Required: serial_out=1, tx_done=0, no frame starts during reset.
   - Required: tx_ready=1 in the first cycle after reset.
2. **Single frame:** send 0xA5 with defaults.
   - Required line pattern: 0, 1,0,1,0,0,1,0,1, 1, each held exactly 10 cycles.
   - Required: tx_done high exactly at cycle 101 after accept, tx_ready low throughout cycles 1–100.
3. **Back-to-back:** hold tx_valid high with 0x00 then 0xFF.
   - Required: second start bit begins exactly 102 cycles after the first accept edge, with one idle-high cycle between frames.
   - Required: two tx_done pulses, 101 cycles apart.
4. **Input isolation:** change tx_data to 0x00 and pulse tx_valid during data bit 2 of a 0xFF frame.
   - Required: the transmitted frame stays 0xFF, and no second frame starts.
5. **Reset mid-frame:** assert rst for 1 cycle during data bit 3.
   - Required: serial_out=1 from the next cycle, no tx_done, tx_ready=1 after reset.
   - Required: a following 0x5A frame transmits correctly.
6. **Parameter corner:** CLKS_PER_BIT=1, DATA_BITS=8, send 0x81.
   - Required: a 10-cycle frame 0,1,0,0,0,0,0,0,1,1, with tx_done at cycle 11 after accept.
